// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone cache arbiter.
package wb_arb_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat_m;
  } master_req_t;

endpackage

// File: rtl/wb_req_mux.sv
// Combinational request mux: forwards the granted master's request, zero when idle.
module wb_req_mux
  import wb_arb_pkg::*;
(
  input  arb_state_t  state,
  input  master_req_t req_i,
  input  master_req_t req_d,
  output master_req_t req_m
);

  always_comb begin
    req_m = '0;
    case (state)
      GNT_I:   req_m = req_i;
      GNT_D:   req_m = req_d;
      default: req_m = '0;
    endcase
  end

endmodule

// File: rtl/wb_cache_arbiter.sv
// Arbitrates icache/dcache Wishbone masters onto one memory port, one line per grant.
// Optional WB_ARB_ROUND_ROBIN_EN: contention goes to the master not granted last.
module wb_cache_arbiter
  import wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  output logic              i_rty,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              d_rty,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0] m_dat_m,
  input  logic [DATA_W-1:0] m_dat_s,
  input  logic              m_ack,
  input  logic              m_rty
);

  arb_state_t  state_q, state_d;
  master_req_t req_i, req_d, req_m;
  logic        i_req, d_req;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 1 = dcache held the most recent grant
  logic last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Every grant ends through IDLE, so a lowered cyc is always observed before re-arbitration
  always_comb begin
    state_d = state_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && i_req) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_d = last_grant_q ? GNT_I : GNT_D;
`else
          state_d = GNT_D;
`endif
        end else if (d_req) begin
          state_d = GNT_D;
        end else if (i_req) begin
          state_d = GNT_I;
        end
      end
      GNT_I: if (m_ack || m_rty || !i_cyc) state_d = IDLE;
      GNT_D: if (m_ack || m_rty || !d_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef WB_ARB_ROUND_ROBIN_EN
    if (state_q == IDLE && state_d == GNT_D) last_grant_d = 1'b1;
    if (state_q == IDLE && state_d == GNT_I) last_grant_d = 1'b0;
`endif
  end

  assign req_i = '{cyc: i_cyc, stb: i_stb, we: i_we, adr: i_adr, sel: i_sel, dat_m: i_dat_m};
  assign req_d = '{cyc: d_cyc, stb: d_stb, we: d_we, adr: d_adr, sel: d_sel, dat_m: d_dat_m};

  wb_req_mux u_req_mux (
    .state (state_q),
    .req_i (req_i),
    .req_d (req_d),
    .req_m (req_m)
  );

  assign m_cyc   = req_m.cyc;
  assign m_stb   = req_m.stb;
  assign m_we    = req_m.we;
  assign m_adr   = req_m.adr;
  assign m_sel   = req_m.sel;
  assign m_dat_m = req_m.dat_m;

  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;
  assign i_ack   = m_ack & (state_q == GNT_I);
  assign i_rty   = m_rty & (state_q == GNT_I);
  assign d_ack   = m_ack & (state_q == GNT_D);
  assign d_rty   = m_rty & (state_q == GNT_D);

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// Directed self-checking bench for wb_cache_arbiter.
module tb_wb_cache_arbiter;
  import wb_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] i_adr, d_adr, m_adr;
  logic [SEL_W-1:0]  i_sel, d_sel, m_sel;
  logic [DATA_W-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s, m_dat_m, m_dat_s;
  logic              i_ack, i_rty, d_ack, d_rty;
  logic              m_cyc, m_stb, m_we, m_ack, m_rty;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DATA_W-1:0] RD_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [DATA_W-1:0] WR_DATA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  always #5 clk = ~clk;

  wb_cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_rty(m_rty)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_sel = '0; i_dat_m = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_sel = '0; d_dat_m = '0;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_order [4];
    clear_masters();
    m_dat_s = '0; m_ack = 0; m_rty = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("reset_m_cyc", 128'(m_cyc), 128'(0));
    check("reset_m_adr", 128'(m_adr), 128'(0));
    check("reset_acks", 128'({i_ack, i_rty, d_ack, d_rty}), 128'(0));

    // icache-only read with a 3-cycle memory latency
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 28'h0000040; i_sel = 16'hFFFF;
    #1 check("icache_grant_latency", 128'(m_cyc), 128'(0));
    tick();
    check("icache_m_cyc", 128'({m_cyc, m_stb}), 128'(2'b11));
    check("icache_m_adr", 128'(m_adr), 128'(28'h0000040));
    check("icache_m_we", 128'(m_we), 128'(0));
    tick(); tick();
    check("icache_wait_no_ack", 128'(i_ack), 128'(0));
    tick();
    m_ack = 1; m_dat_s = RD_DATA;
    #1 check("icache_i_ack", 128'(i_ack), 128'(1));
    check("icache_i_dat_s", i_dat_s, RD_DATA);
    check("icache_d_dat_s_bcast", d_dat_s, RD_DATA);
    check("icache_d_ack_quiet", 128'(d_ack), 128'(0));
    tick();
    m_ack = 0; i_cyc = 0; i_stb = 0;
    #1 check("icache_ack_pulse", 128'(i_ack), 128'(0));
    check("icache_back_idle", 128'(m_cyc), 128'(0));

    // Simultaneous: dcache write beats icache read, one IDLE cycle between grants
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 28'h10;
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 28'h20; d_sel = 16'hFFFF; d_dat_m = WR_DATA;
    tick();
    check("sim_d_first_adr", 128'(m_adr), 128'(28'h20));
    check("sim_d_first_we", 128'(m_we), 128'(1));
    check("sim_d_sel", 128'(m_sel), 128'(16'hFFFF));
    check("sim_d_dat_m", m_dat_m, WR_DATA);
    m_ack = 1;
    #1 check("sim_d_ack", 128'({d_ack, i_ack}), 128'(2'b10));
    tick();
    m_ack = 0; clear_masters(); i_cyc = 1; i_stb = 1; i_adr = 28'h10;
    #1 check("sim_idle_gap", 128'(m_cyc), 128'(0));
    tick();
    check("sim_i_second_adr", 128'(m_adr), 128'(28'h10));
    check("sim_i_second_we", 128'({m_cyc, m_we}), 128'(2'b10));
    m_ack = 1;
    #1 check("sim_i_ack", 128'({d_ack, i_ack}), 128'(2'b01));
    tick();
    m_ack = 0; clear_masters();

    // Abort: dcache drops cyc before any ack, then a late ack lands in IDLE
    tick();
    d_cyc = 1; d_stb = 1; d_adr = 28'h30;
    tick();
    check("abort_granted", 128'(m_cyc), 128'(1));
    d_cyc = 0; d_stb = 0;
    tick();
    check("abort_m_cyc", 128'(m_cyc), 128'(0));
    m_ack = 1;
    #1 check("abort_late_ack", 128'({i_ack, d_ack}), 128'(0));
    tick();
    m_ack = 0;

    // Retry during an icache grant
    i_cyc = 1; i_stb = 1; i_adr = 28'h50;
    tick();
    check("rty_granted", 128'(m_adr), 128'(28'h50));
    m_rty = 1;
    #1 check("rty_i_rty", 128'({i_rty, i_ack, d_rty}), 128'(3'b100));
    tick();
    m_rty = 0;
    #1 check("rty_back_idle", 128'(m_cyc), 128'(0));
    clear_masters();

    // Continuous contention for 4 transactions
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_order = '{28'h20, 28'h10, 28'h20, 28'h10};
`else
    exp_order = '{28'h20, 28'h20, 28'h20, 28'h20};
`endif
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 28'h10;
    d_cyc = 1; d_stb = 1; d_adr = 28'h20;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("contend_adr_%0d", k), 128'(m_adr), 128'(exp_order[k]));
      m_ack = 1;
      tick();
      m_ack = 0;
      #1 check($sformatf("contend_gap_%0d", k), 128'(m_cyc), 128'(0));
    end
    clear_masters();

    // Asynchronous reset in the middle of a dcache grant
    tick();
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 28'h60; d_sel = 16'h00FF; d_dat_m = WR_DATA;
    tick();
    check("rst_pre_m_cyc", 128'(m_cyc), 128'(1));
    #2 rst = 1;
    #1 check("rst_async_m_cyc", 128'(m_cyc), 128'(0));
    check("rst_outputs_zero", 128'({m_stb, m_we, m_adr, m_sel}), 128'(0));
    check("rst_dat_m_zero", m_dat_m, 128'(0));
    tick();
    clear_masters();
    rst = 0;
    tick();
    check("rst_idle_after", 128'(m_cyc), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_cache_arbiter.md
Name: wb_cache_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that sits between the split L1 caches and the single physical memory port.
- Masters are the icache and dcache bus ports of the mainpc core; the slave is physical_memory.
- Grants one cache at a time for a whole cache-line transaction, forwarding request signals down and response signals back.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- DATA_W, 128, cache-line data width.
- SEL_W, 16, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_cyc, i_stb, i_we  in  1 each  icache master cycle, strobe and write-enable.
- i_adr  in  ADDR_W  icache line address.
- i_sel  in  SEL_W  icache byte selects.
- i_dat_m  in  DATA_W  icache write data.
- i_dat_s  out  DATA_W  read data to icache.
- i_ack, i_rty  out  1 each  icache acknowledge and retry.
- d_*  same set as i_* for the dcache master.
- m_cyc, m_stb, m_we  out  1 each  memory cycle, strobe and write-enable.
- m_adr  out  ADDR_W  memory line address.
- m_sel  out  SEL_W  memory byte selects.
- m_dat_m  out  DATA_W  memory write data.
- m_dat_s  in  DATA_W  memory read data.
- m_ack, m_rty  in  1 each  memory acknowledge and retry.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Asynchronous reset forces IDLE.
- Reset values: m_cyc, m_stb, m_we = 0; m_adr, m_sel, m_dat_m = 0; i_ack, i_rty, d_ack, d_rty = 0.
- A request means cyc & stb on a master.
- IDLE transitions:
  - dcache request -> GNT_D.
  - Otherwise icache request -> GNT_I.
  - Simultaneous requests: dcache wins (fixed priority).
  - No request -> stay in IDLE.
- Grant latency: one cycle from request to m_cyc/m_stb asserted; the grant is registered.
- In a GNT state, all m_* request outputs equal the granted master's signals combinationally, so cyc/stb/we/adr/sel/dat_m track that master each cycle.
- In IDLE, all m_* outputs are 0.
- Response routing:
  - m_dat_s is broadcast to both i_dat_s and d_dat_s.
  - m_ack/m_rty reach only the granted master; the other master always sees ack = rty = 0.
- Leaving a GNT state (-> IDLE on that edge) happens on:
  - m_ack = 1 or m_rty = 1 (end of transaction), or
  - the granted master dropping cyc (abort).
- After every transaction the FSM spends at least one IDLE cycle before a new grant. This guarantees a master's lowered cyc is seen and prevents double-acking.
- A waiting request is held off indefinitely: the arbiter adds no timeout.
- Reset mid-transaction: state returns to IDLE immediately and m_cyc drops asynchronously. The in-flight ack is lost, and memory must tolerate cyc dropping.
- Memory ack latency is arbitrary (≥1 cycle). Acks arriving while in IDLE are ignored.

Optional Feature:
- Macro WB_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset 0 = icache) decides simultaneous requests in IDLE. The master not granted last wins, so alternating contention yields D,I,D,I...
- Undefined: fixed dcache priority as above; no extra register.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_state_t enum (IDLE, GNT_I, GNT_D).
  - Constants ADDR_W/DATA_W/SEL_W defaults.
  - A master_req_t struct {cyc, stb, we, adr, sel, dat_m}.
- One sub-module is natural: wb_req_mux. It is combinational, selects master_req_t by grant, and zeroes the output when neither master is granted.
- The FSM stays in the top module.

Test Plan:
- Reset: assert rst mid-GNT_D with m_cyc = 1 -> m_cyc = 0 in the same cycle; all outputs 0; state IDLE after release.
- icache-only read: i_cyc = i_stb = 1, i_adr = 28'h0000040 -> next cycle m_adr = 28'h0000040, m_we = 0. Memory acks after 3 cycles with m_dat_s = 128'hDEAD_BEEF... -> i_ack pulses 1 cycle with that data; d_ack stays 0.
- Simultaneous: icache read 28'h10 and dcache write 28'h20 with d_sel = 16'hFFFF asserted the same cycle -> dcache served first (m_we = 1, m_adr = 28'h20). After its ack, one IDLE cycle, then icache served at 28'h10.
- Abort: dcache granted, d_cyc dropped before ack -> m_cyc = 0 next cycle. A late m_ack in IDLE reaches neither master.
- Retry: m_rty = 1 during GNT_I -> i_rty = 1 for that cycle, i_ack = 0, FSM back to IDLE.
- WB_ARB_ROUND_ROBIN_EN defined, both masters requesting continuously for 4 transactions -> grant order D, I, D, I.
